// File: rtl/blade_launcher.sv
// blade_launcher: fire-control stage in front of the blade projectile block.
// Turns the raw fire button into a one-cycle shoot pulse, only while the blade
// is idle, enforces a post-shot cooldown and manages a rechargeable charge pool.
// Each launch is confirmed by blade_active; a missing acknowledgement latches
// ack_fault until reset.
//
// Optional feature: define FIRE_BUFFER_EN to keep a one-entry pending flag for
// presses that cannot be accepted immediately; they fire once IDLE can accept.
//
// Ports:
//   sim_clk      in   system clock, all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   btn_fire     in   raw fire button, asynchronous to sim_clk
//   blade_active in   blade isActive bit (bladeState[0])
//   shoot        out  registered one-cycle launch pulse to the blade
//   ready        out  IDLE with a charge available and the blade inactive
//   charges      out  current charge count
//   ack_fault    out  sticky: a launch timed out without blade_active
module blade_launcher #(
  parameter int unsigned COOLDOWN_TICKS = 4,
  parameter int unsigned MAX_CHARGES    = 3,
  parameter int unsigned RECHARGE_TICKS = 8,
  parameter int unsigned ACK_TIMEOUT    = 4
) (
  input  logic       sim_clk,
  input  logic       reset,
  input  logic       btn_fire,
  input  logic       blade_active,
  output logic       shoot,
  output logic       ready,
  output logic [3:0] charges,
  output logic       ack_fault
);

  localparam logic [7:0] CD_LAST  = 8'(COOLDOWN_TICKS - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RC_LAST  = 8'(RECHARGE_TICKS - 1);
  localparam logic [3:0] CHG_MAX  = 4'(MAX_CHARGES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    COOLDOWN
  } state_t;

  state_t     state, state_nxt;
  logic       s1, s2, btn_prev;
  logic       press, fire_req, accept, rc_tick;
  logic [7:0] timer, timer_nxt;
  logic [7:0] rc_cnt, rc_nxt;
  logic [3:0] charges_nxt;
  logic       fault_nxt;

  // Two-flop synchronizer plus edge detector on the synchronized button.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      s1       <= btn_fire;
      s2       <= s1;
      btn_prev <= s2;
    end
  end

  assign press = s2 & ~btn_prev;

`ifdef FIRE_BUFFER_EN
  logic pending, pending_nxt;

  assign fire_req = press | pending;

  // Any press that is not accepted this edge is remembered; repeats merge.
  always_comb begin
    pending_nxt = pending;
    if (accept)     pending_nxt = 1'b0;
    else if (press) pending_nxt = 1'b1;
  end

  always_ff @(posedge sim_clk) begin
    if (reset) pending <= 1'b0;
    else       pending <= pending_nxt;
  end
`else
  assign fire_req = press;
`endif

  assign accept  = (state == IDLE) && fire_req && (charges != '0) && !blade_active;
  assign rc_tick = (charges < CHG_MAX) && (rc_cnt == RC_LAST);

  // State register.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      rc_cnt    <= '0;
      charges   <= CHG_MAX;
      shoot     <= 1'b0;
      ack_fault <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      rc_cnt    <= rc_nxt;
      charges   <= charges_nxt;
      shoot     <= accept;
      ack_fault <= fault_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    fault_nxt = ack_fault;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT_ACK;
          timer_nxt = '0;
        end
      end
      WAIT_ACK: begin
        if (blade_active) begin
          state_nxt = COOLDOWN;
          timer_nxt = CD_LAST;
        end else if (timer == ACK_LAST) begin
          state_nxt = COOLDOWN;
          timer_nxt = CD_LAST;
          fault_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      COOLDOWN: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - 8'd1;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    // A launch and a recharge tick on the same edge cancel; rc_tick is only
    // possible below capacity and accept only above zero, so no wrap occurs.
    if (charges >= CHG_MAX || rc_tick) rc_nxt = '0;
    else                               rc_nxt = rc_cnt + 8'd1;
    charges_nxt = charges + {3'b000, rc_tick} - {3'b000, accept};
  end

  // Output logic.
  always_comb begin
    ready = (state == IDLE) && (charges != '0) && !blade_active;
  end

endmodule

// File: tb/tb_blade_launcher.sv
// Directed testbench for blade_launcher. RECHARGE_TICKS is raised to 24 so
// that three back-to-back shots can empty the pool before a charge returns.
// Inputs are driven 1 time unit after a rising edge (sampled at the next one);
// outputs are checked at the same point, reflecting the edge just taken.
module tb_blade_launcher;

  logic       sim_clk;
  logic       reset;
  logic       btn_fire;
  logic       blade_active;
  logic       shoot;
  logic       ready;
  logic [3:0] charges;
  logic       ack_fault;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef FIRE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  blade_launcher #(
    .COOLDOWN_TICKS(4),
    .MAX_CHARGES   (3),
    .RECHARGE_TICKS(24),
    .ACK_TIMEOUT   (4)
  ) dut (
    .sim_clk     (sim_clk),
    .reset       (reset),
    .btn_fire    (btn_fire),
    .blade_active(blade_active),
    .shoot       (shoot),
    .ready       (ready),
    .charges     (charges),
    .ack_fault   (ack_fault)
  );

  initial sim_clk = 1'b0;
  always #5 sim_clk = ~sim_clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge sim_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    btn_fire     = 1'b0;
    blade_active = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // One-cycle button pulse (sampled at E1), accept at E3, blade acknowledges
  // at E4; returns just after E6 so the next call's press lands in IDLE.
  task automatic shot_with_ack(input string tag, input logic [31:0] exp_chg);
    btn_fire = 1'b1;
    step(1);
    btn_fire = 1'b0;
    step(2);
    check({tag, "_shoot"}, 32'(shoot), 1);
    check({tag, "_chg"}, 32'(charges), exp_chg);
    blade_active = 1'b1;
    step(1);
    blade_active = 1'b0;
    step(2);
  endtask

  initial begin
    // Reset state
    reset        = 1'b1;
    btn_fire     = 1'b0;
    blade_active = 1'b0;
    step(3);
    check("rst_shoot", 32'(shoot), 0);
    check("rst_chg", 32'(charges), 3);
    check("rst_fault", 32'(ack_fault), 0);
    check("rst_ready", 32'(ready), 1);
    reset = 1'b0;
    step(1);

    // Launch latency, held button, cooldown gating
    btn_fire = 1'b1;
    step(1);
    check("lat_e1_shoot", 32'(shoot), 0);
    step(1);
    check("lat_e2_shoot", 32'(shoot), 0);
    check("lat_e2_chg", 32'(charges), 3);
    step(1);
    check("lat_e3_shoot", 32'(shoot), 1);
    check("lat_e3_chg", 32'(charges), 2);
    check("lat_e3_ready", 32'(ready), 0);
    btn_fire     = 1'b0;
    blade_active = 1'b1;
    step(1);
    check("lat_e4_shoot", 32'(shoot), 0);
    btn_fire = 1'b1;
    step(1);
    btn_fire = 1'b0;
    step(3);
    check("cd_e8_ready_blade", 32'(ready), 0);
    check("cd_e8_shoot", 32'(shoot), 0);
    blade_active = 1'b0;
    step(1);
    check("cd_e9_shoot", 32'(shoot), BUF ? 1 : 0);
    check("cd_e9_chg", 32'(charges), BUF ? 1 : 2);
    step(1);
    check("cd_e10_shoot", 32'(shoot), 0);
    step(16);
    check("rc_e26_chg", 32'(charges), BUF ? 1 : 2);
    step(1);
    check("rc_e27_chg", 32'(charges), BUF ? 2 : 3);

    // Charge exhaustion and recharge (first accept edge = A)
    do_reset();
    shot_with_ack("ex1", 2);
    shot_with_ack("ex2", 1);
    shot_with_ack("ex3", 0);
    check("ex_a15_ready", 32'(ready), 0);
    step(2);
    check("ex_a17_ready", 32'(ready), 0);
    check("ex_a17_chg", 32'(charges), 0);
    btn_fire = 1'b1;
    step(1);
    btn_fire = 1'b0;
    step(2);
    check("ex_a20_shoot", 32'(shoot), 0);
    check("ex_a20_ready", 32'(ready), 0);
    step(3);
    check("ex_a23_chg", 32'(charges), 0);
    step(1);
    check("ex_a24_chg", 32'(charges), 1);
    check("ex_a24_ready", 32'(ready), 1);
    check("ex_a24_shoot", 32'(shoot), 0);
    step(1);
    check("ex_a25_shoot", 32'(shoot), BUF ? 1 : 0);
    check("ex_a25_chg", 32'(charges), BUF ? 0 : 1);

    // Ack timeout, launch on a recharge tick, reset during WAIT_ACK
    do_reset();
    btn_fire = 1'b1;
    step(1);
    btn_fire = 1'b0;
    step(2);
    check("to_x_shoot", 32'(shoot), 1);
    check("to_x_chg", 32'(charges), 2);
    step(3);
    check("to_x3_fault", 32'(ack_fault), 0);
    step(1);
    check("to_x4_fault", 32'(ack_fault), 1);
    step(3);
    check("to_x7_ready", 32'(ready), 0);
    step(1);
    check("to_x8_ready", 32'(ready), 1);
    step(13);
    btn_fire = 1'b1;
    step(1);
    btn_fire = 1'b0;
    step(1);
    check("sim_x23_chg", 32'(charges), 2);
    step(1);
    check("sim_x24_shoot", 32'(shoot), 1);
    check("sim_x24_chg", 32'(charges), 2);
    check("sim_x24_rc", 32'(dut.rc_cnt), 0);
    check("sim_x24_fault", 32'(ack_fault), 1);
    step(1);
    check("sim_x25_shoot", 32'(shoot), 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mrst_shoot", 32'(shoot), 0);
    check("mrst_chg", 32'(charges), 3);
    check("mrst_fault", 32'(ack_fault), 0);
    check("mrst_ready", 32'(ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
